// File: rtl/iir_pkg.sv
// Shared constants and state encoding for the IIR cascade controller.
package iir_pkg;
  localparam int NCOEF = 5;
  localparam int C_B0  = 0;
  localparam int C_B1  = 1;
  localparam int C_B2  = 2;
  localparam int C_A1  = 3;
  localparam int C_A2  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    CLR  = 2'd2
  } state_t;
endpackage

// File: rtl/iir_coef_bank.sv
// Shadow/active coefficient banks: register-style shadow writes, whole-bank swap on strobe.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int CASCADE_LEVEL = 2,
  parameter int CWIDTH        = 16,
  localparam int NK           = CASCADE_LEVEL * NCOEF,
  localparam int AW           = $clog2(NK)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [AW-1:0]        addr,
  input  logic [CWIDTH-1:0]    wdata,
  input  logic                 swap,
  output logic [NK*CWIDTH-1:0] coefs
);
  logic [NK-1:0][CWIDTH-1:0] shadow;
  logic [NK-1:0][CWIDTH-1:0] active;
  logic                      addr_ok;

  // addr space is a power of two, so indices past the last stage must be dropped
  assign addr_ok = (int'(addr) < NK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow <= '0;
      active <= '0;
    end else begin
      // swap reads the pre-edge shadow, so a write on the swap edge waits for the next commit
      if (swap) active <= shadow;
      for (int k = 0; k < NK; k++)
        if (wr_en && addr_ok && addr == AW'(k)) shadow[k] <= wdata;
    end
  end

  assign coefs = active;
endmodule

// File: rtl/iir_cascade_ctrl.sv
// Front-end for iir_cascade: coefficient commit, sample metering, block enable.
// Define IIR_CLR_ON_COMMIT_EN to flush the cascade (block_en low 2 cycles) on every enabled commit.
module iir_cascade_ctrl
  import iir_pkg::*;
#(
  parameter int CASCADE_LEVEL = 2,
  parameter int DWIDTH        = 24,
  parameter int CWIDTH        = 16,
  parameter int SAMPLE_GAP    = 16
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   enable,
  input  logic                                   cfg_wr_en,
  input  logic [$clog2(CASCADE_LEVEL*NCOEF)-1:0] cfg_addr,
  input  logic [CWIDTH-1:0]                      cfg_wdata,
  input  logic                                   cfg_commit,
  output logic                                   cfg_busy,
  input  logic                                   s_vld,
  output logic                                   s_rdy,
  input  logic [DWIDTH-1:0]                      s_data,
  output logic                                   block_en,
  output logic [CASCADE_LEVEL*CWIDTH*NCOEF-1:0]  coefs,
  output logic                                   din_vld,
  output logic [DWIDTH-1:0]                      din
);
  localparam int CW = $clog2(SAMPLE_GAP + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend, pend_n;
  logic          swap, take, blk_n;

  iir_coef_bank #(
    .CASCADE_LEVEL (CASCADE_LEVEL),
    .CWIDTH        (CWIDTH)
  ) u_bank (
    .clk   (clk),
    .rstn  (rstn),
    .wr_en (cfg_wr_en),
    .addr  (cfg_addr),
    .wdata (cfg_wdata),
    .swap  (swap),
    .coefs (coefs)
  );

  assign s_rdy    = (state == IDLE) && enable && !pend;
  assign cfg_busy = pend;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    swap    = 1'b0;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (pend) begin
          swap   = 1'b1;
          pend_n = 1'b0;
`ifdef IIR_CLR_ON_COMMIT_EN
          if (enable) begin
            state_n = CLR;
            cnt_n   = CW'(1);
          end
`endif
        end else if (s_vld && s_rdy) begin
          take    = 1'b1;
          state_n = GAP;
          cnt_n   = CW'(SAMPLE_GAP - 1);
        end
      end
      GAP, CLR: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // a commit already pending absorbs repeats, including one on the swap edge
    if (cfg_commit && !pend) pend_n = 1'b1;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

`ifdef IIR_CLR_ON_COMMIT_EN
  assign blk_n = enable && (state_n != CLR);
`else
  assign blk_n = enable;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= 1'b0;
      din      <= '0;
      din_vld  <= 1'b0;
      block_en <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend     <= pend_n;
      din_vld  <= take;
      block_en <= blk_n;
      if (take) din <= s_data;
    end
  end
endmodule

// File: tb/tb_iir_cascade_ctrl.sv
// Directed bench for iir_cascade_ctrl: cycle-indexed reference model plus literal spot checks.
module tb_iir_cascade_ctrl;
  localparam int CL = 2, DW = 24, CWD = 16, G = 16;
  localparam int NK = CL * 5, AW = $clog2(NK);
`ifdef IIR_CLR_ON_COMMIT_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0, enable = 1'b0;
  logic cfg_wr_en = 1'b0, cfg_commit = 1'b0, s_vld = 1'b0;
  logic [AW-1:0]  cfg_addr  = '0;
  logic [CWD-1:0] cfg_wdata = '0;
  logic [DW-1:0]  s_data    = '0;
  logic cfg_busy, s_rdy, block_en, din_vld;
  logic [NK*CWD-1:0] coefs;
  logic [DW-1:0]     din;

  always #5 clk = ~clk;

  iir_cascade_ctrl #(.CASCADE_LEVEL(CL), .DWIDTH(DW), .CWIDTH(CWD), .SAMPLE_GAP(G)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
    .block_en(block_en), .coefs(coefs), .din_vld(din_vld), .din(din)
  );

  int pass_cnt = 0, tot_cnt = 0;

  task automatic chk(input string nm, input logic [NK*CWD-1:0] act, input logic [NK*CWD-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: tracks the cycle index at which the block is next free,
  // rather than any state machine.
  int  cyc = 0, free_cyc = 0, clr_left = 0;
  bit  m_pend = 0, m_vld = 0, m_blk = 0;
  logic [DW-1:0]             m_din = '0;
  logic [NK-1:0][CWD-1:0]    m_sh  = '0, m_act = '0;

  function automatic bit m_rdy();
    return enable && (cyc >= free_cyc) && !m_pend;
  endfunction

  task automatic model_step();
    bit hs, sw, pend_old;
    if (!rstn) begin
      free_cyc = 0; clr_left = 0; m_pend = 0; m_vld = 0; m_blk = 0;
      m_din = '0; m_sh = '0; m_act = '0;
      return;
    end
    pend_old = m_pend;
    hs = s_vld && m_rdy();
    sw = (cyc >= free_cyc) && m_pend;
    m_vld = hs;
    if (hs) begin m_din = s_data; free_cyc = cyc + 1 + G; end
    if (clr_left > 0) clr_left--;
    if (sw) begin
      m_act = m_sh;
      if (CLR_EN && enable) begin clr_left = 2; free_cyc = cyc + 3; end
    end
    if (!enable) begin clr_left = 0; if (free_cyc > cyc + 1) free_cyc = cyc + 1; end
    m_pend = (m_pend && !sw) || (cfg_commit && !pend_old);
    if (cfg_wr_en && int'(cfg_addr) < NK) m_sh[cfg_addr] = cfg_wdata;
    m_blk = enable && (clr_left == 0);
    cyc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  // din_vld pulse log for spacing checks
  bit rec_on = 0;
  int vld_cyc[$];
  logic [DW-1:0] vld_dat[$];

  initial forever begin
    @(negedge clk);
    chk("s_rdy",    s_rdy,    m_rdy());
    chk("cfg_busy", cfg_busy, m_pend);
    chk("din_vld",  din_vld,  m_vld);
    chk("din",      din,      m_din);
    chk("block_en", block_en, m_blk);
    chk("coefs",    coefs,    m_act);
    if (rec_on && din_vld) begin vld_cyc.push_back(cyc); vld_dat.push_back(din); end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_rdy(input string nm);
    int n = 0;
    while (!s_rdy && n < 100) begin tick(); n++; end
    chk(nm, s_rdy, 1);
  endtask

  task automatic wr(input int a, input logic [CWD-1:0] d);
    cfg_wr_en = 1; cfg_addr = AW'(a); cfg_wdata = d; tick();
    cfg_wr_en = 0;
  endtask

  task automatic commit();
    cfg_commit = 1; tick(); cfg_commit = 0;
  endtask

  initial begin
    logic [NK*CWD-1:0] snap;
    int n, hi, z, first, hs_cnt;
    bit hs;

    tick(); tick();
    chk("rst_coefs", coefs, 0);
    chk("rst_rdy", s_rdy, 0);
    chk("rst_blk", block_en, 0);
    chk("rst_vld", din_vld, 0);
    rstn = 1; enable = 1; tick();
    chk("en_blk", block_en, 1);

    // load 1..10 and commit
    for (int k = 0; k < NK; k++) wr(k, CWD'(k + 1));
    commit();
    chk("busy_t1", cfg_busy, 1);
    chk("coefs_t1", coefs, 0);
    tick();
    chk("busy_t2", cfg_busy, 0);
    for (int k = 0; k < NK; k++) chk($sformatf("coef%0d", k), coefs[k*CWD +: CWD], k + 1);
    tick(); tick();
    chk("blk_after_commit", block_en, 1);

    // three back-to-back samples with s_vld held
    rec_on = 1; s_vld = 1; s_data = 100; hs_cnt = 0; n = 0;
    while (hs_cnt < 3 && n < 200) begin
      hs = s_rdy && s_vld;
      tick(); n++;
      if (hs) begin hs_cnt++; s_data = DW'(100 * (hs_cnt + 1)); end
    end
    s_vld = 0;
    repeat (4) tick();
    rec_on = 0;
    chk("n_pulses", vld_cyc.size(), 3);
    if (vld_cyc.size() == 3) begin
      chk("gap01", vld_cyc[1] - vld_cyc[0], 17);
      chk("gap12", vld_cyc[2] - vld_cyc[1], 17);
      chk("din0", vld_dat[0], 100);
      chk("din1", vld_dat[1], 200);
      chk("din2", vld_dat[2], 300);
    end
    repeat (14) tick();

    // commit one cycle after a handshake: swap waits for GAP to finish
    wr(0, 16'h00AA);
    s_vld = 1; s_data = 400; wait_rdy("rdy_t4");
    tick(); s_vld = 0;
    commit();
    n = 0; hi = 0;
    while (coefs[15:0] != 16'h00AA && n < 40) begin
      if (s_rdy) hi++;
      tick(); n++;
    end
    chk("swap_delay", n, 16);
    chk("rdy_during_wait", hi, 0);
    repeat (5) tick();

    // out-of-range write is dropped
    snap = coefs;
    wr(12, 16'h7777);
    commit();
    repeat (4) tick();
    chk("oor_unchanged", coefs, snap);

    // commit while idle: flush window
    wr(1, 16'h0BBB);
    commit();
    z = 0; first = -1;
    for (int i = 0; i < 7; i++) begin
      if (!block_en) z++;
      if (s_rdy && first < 0) first = i;
      tick();
    end
    chk("clr_lo_cycles", z, CLR_EN ? 2 : 0);
    chk("clr_rdy_return", first, CLR_EN ? 3 : 1);
    chk("coef1_bbb", coefs[1*CWD +: CWD], 16'h0BBB);

    // disable mid-GAP with a commit pending
    wr(2, 16'h0CCC);
    s_vld = 1; s_data = 500; wait_rdy("rdy_t7");
    tick(); s_vld = 0;
    commit();
    repeat (3) tick();
    enable = 0; tick();
    chk("dis_blk", block_en, 0);
    chk("dis_rdy", s_rdy, 0);
    tick();
    chk("dis_swap", coefs[2*CWD +: CWD], 16'h0CCC);
    chk("dis_busy", cfg_busy, 0);
    hi = 0;
    repeat (3) begin if (s_rdy) hi++; tick(); end
    chk("dis_rdy_hold", hi, 0);
    enable = 1; tick();
    chk("reen_blk", block_en, 1);
    chk("reen_rdy", s_rdy, 1);

    // reset mid-GAP clears everything, including the shadow bank
    wr(3, 16'h0DDD);
    s_vld = 1; s_data = 600; wait_rdy("rdy_t8");
    tick(); s_vld = 0;
    tick(); tick();
    rstn = 0; #1;
    chk("mid_rst_coefs", coefs, 0);
    chk("mid_rst_din", din, 0);
    chk("mid_rst_blk", block_en, 0);
    tick(); rstn = 1;
    commit();
    tick(); tick();
    chk("shadow_cleared", coefs, 0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
